// File: rtl/sdrc_pkg.sv
// ============================================================================
//  Module      : sdrc_pkg
//  Description : Shared encodings and address-map helper for the SDRAM
//                request splitter (state, column-bits and SDRAM-width codes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdrc_pkg;

  // Request splitter states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // cfg_colbits encodings (number of column address bits)
  localparam logic [1:0] COLBITS_8  = 2'b00;
  localparam logic [1:0] COLBITS_9  = 2'b01;
  localparam logic [1:0] COLBITS_10 = 2'b10;
  localparam logic [1:0] COLBITS_11 = 2'b11;

  // sdr_width encodings (2'b11 is also treated as 8 bit)
  localparam logic [1:0] SDR_W32 = 2'b00;
  localparam logic [1:0] SDR_W16 = 2'b01;
  localparam logic [1:0] SDR_W8  = 2'b10;

  localparam int REQ_ID_W_DEF = 4;

  // The map is computed at a generous fixed width; callers cast down
  localparam int MAP_AW = 64;

  typedef struct packed {
    logic [7:0]  ba;
    logic [31:0] row;
    logic [15:0] col;
  } addr_map_t;

  // Split a linear SDRAM address into column (low colbits), bank (next
  // ba_w bits) and row (everything above).
  function automatic addr_map_t addr_map(input logic [MAP_AW-1:0] addr,
                                         input logic [1:0]        colbits,
                                         input int unsigned       ba_w);
    addr_map_t   m;
    int unsigned cb;
    logic [MAP_AW-1:0] cmask;
    logic [MAP_AW-1:0] bmask;
    cb    = 32'd8 + 32'(colbits);
    cmask = (64'd1 << cb) - 64'd1;
    bmask = (64'd1 << ba_w) - 64'd1;
    m.col = 16'(addr & cmask);
    m.ba  = 8'((addr >> cb) & bmask);
    m.row = 32'(addr >> (cb + ba_w));
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdrc_chunk_calc.sv
// ============================================================================
//  Module      : sdrc_chunk_calc
//  Description : Combinational chunk sizing: length of the next chunk is the
//                remaining length, clipped to the end of the current page
//                and to MAX_CHUNK beats (no clipping for wrap requests).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrc_chunk_calc #(
  parameter int LW        = 11,
  parameter int REQ_BW    = 12,
  parameter int MAX_CHUNK = 32
) (
  input  logic [1:0]        colbits_i,
  input  logic [15:0]       col_i,
  input  logic [LW-1:0]     rem_i,
  input  logic              wrap_i,
  output logic [REQ_BW-1:0] len_o,
  output logic              last_o
);

  logic [31:0] page_size;
  logic [31:0] page_rem;
  logic [31:0] rem32;
  logic [31:0] min_page;
  logic [31:0] len32;

  // Page size is 2^colbits beats; distance to the page end bounds the chunk
  assign page_size = 32'd1 << (32'd8 + 32'(colbits_i));
  assign page_rem  = page_size - 32'(col_i);
  assign rem32     = 32'(rem_i);
  assign min_page  = (rem32 < page_rem) ? rem32 : page_rem;

  // Wrap requests stay inside their page in the SDRAM, so they go out whole
  assign len32  = wrap_i ? rem32
                         : ((min_page < 32'(MAX_CHUNK)) ? min_page : 32'(MAX_CHUNK));
  assign len_o  = REQ_BW'(len32);
  assign last_o = (len32 == rem32);

endmodule

`default_nettype wire

// File: rtl/sdrc_req_split.sv
// ============================================================================
//  Module      : sdrc_req_split
//  Description : Accepts one application request, scales it for the SDRAM
//                width and issues it to the bank controller as a series of
//                page/MAX_CHUNK-bounded chunks with start/last framing.
//                Optional macro SDRC_BANK_HASH_EN: bank = bank ^ row[BA_W-1:0].
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrc_req_split
  import sdrc_pkg::*;
#(
  parameter int APP_AW    = 26,
  parameter int APP_RW    = 9,
  parameter int REQ_ID_W  = REQ_ID_W_DEF,
  parameter int BA_W      = 2,
  parameter int RA_W      = 13,
  parameter int CA_W      = 13,
  parameter int REQ_BW    = 12,
  parameter int MAX_CHUNK = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          cfg_colbits,
  input  logic [1:0]          sdr_width,
  input  logic                req,
  input  logic [REQ_ID_W-1:0] req_id,
  input  logic [APP_AW-1:0]   req_addr,
  input  logic [APP_RW-1:0]   req_len,
  input  logic                req_wrap,
  input  logic                req_wr_n,
  output logic                req_ack,
  output logic                r2x_idle,
  output logic                r2b_req,
  output logic [REQ_ID_W-1:0] r2b_req_id,
  output logic                r2b_start,
  output logic                r2b_last,
  output logic                r2b_wrap,
  output logic [BA_W-1:0]     r2b_ba,
  output logic [RA_W-1:0]     r2b_raddr,
  output logic [CA_W-1:0]     r2b_caddr,
  output logic [REQ_BW-1:0]   r2b_len,
  output logic                r2b_write,
  input  logic                b2r_ack,
  input  logic                b2r_arb_ok
);

  // Internal address carries two extra bits for the 8-bit scaling
  localparam int AW = APP_AW + 2;
  localparam int LW = APP_RW + 2;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [LW-1:0]       rem_q, rem_d;
  logic                first_q, first_d;
  logic [REQ_ID_W-1:0] id_q, id_d;
  logic                wr_q, wr_d;
  logic                wrap_q, wrap_d;
  logic                r2b_req_q, r2b_req_d;
  logic                start_q, start_d;
  logic                last_q, last_d;
  logic [BA_W-1:0]     ba_q, ba_d;
  logic [RA_W-1:0]     raddr_q, raddr_d;
  logic [CA_W-1:0]     caddr_q, caddr_d;
  logic [REQ_BW-1:0]   len_q, len_d;

  logic [AW-1:0]       scaled_addr;
  logic [LW-1:0]       scaled_len;
  addr_map_t           map_w;
  logic [BA_W-1:0]     bank_w;
  logic [RA_W-1:0]     row_w;
  logic [15:0]         col_w;
  logic [BA_W-1:0]     bank_sel;
  logic [REQ_BW-1:0]   calc_len;
  logic                calc_last;

  assign req_ack  = (state_q == ST_IDLE) & req & b2r_arb_ok;
  assign r2x_idle = (state_q == ST_IDLE) & ~req;

  // Convert application word address/length into SDRAM beats
  always_comb begin
    case (sdr_width)
      SDR_W32: begin
        scaled_addr = {2'b00, req_addr};
        scaled_len  = {2'b00, req_len};
      end
      SDR_W16: begin
        scaled_addr = {1'b0, req_addr, 1'b0};
        scaled_len  = {1'b0, req_len, 1'b0};
      end
      default: begin
        scaled_addr = {req_addr, 2'b00};
        scaled_len  = {req_len, 2'b00};
      end
    endcase
  end

  assign map_w  = addr_map(MAP_AW'(addr_q), cfg_colbits, BA_W);
  assign bank_w = BA_W'(map_w.ba);
  assign row_w  = RA_W'(map_w.row);
  assign col_w  = map_w.col;

`ifdef SDRC_BANK_HASH_EN
  // Consecutive rows land in different banks
  assign bank_sel = bank_w ^ row_w[BA_W-1:0];
`else
  assign bank_sel = bank_w;
`endif

  sdrc_chunk_calc #(
    .LW        (LW),
    .REQ_BW    (REQ_BW),
    .MAX_CHUNK (MAX_CHUNK)
  ) u_chunk_calc (
    .colbits_i (cfg_colbits),
    .col_i     (col_w),
    .rem_i     (rem_q),
    .wrap_i    (wrap_q),
    .len_o     (calc_len),
    .last_o    (calc_last)
  );

  // Next-state logic: accept in IDLE, build chunk in LOAD, hold in ACTIVE
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    first_d   = first_q;
    id_d      = id_q;
    wr_d      = wr_q;
    wrap_d    = wrap_q;
    r2b_req_d = r2b_req_q;
    start_d   = start_q;
    last_d    = last_q;
    ba_d      = ba_q;
    raddr_d   = raddr_q;
    caddr_d   = caddr_q;
    len_d     = len_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ack) begin
          id_d    = req_id;
          wr_d    = ~req_wr_n;
          wrap_d  = req_wrap;
          addr_d  = scaled_addr;
          rem_d   = scaled_len;
          first_d = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A zero-length request is swallowed without a chunk
        if (rem_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          r2b_req_d = 1'b1;
          start_d   = first_q;
          last_d    = calc_last;
          ba_d      = bank_sel;
          raddr_d   = row_w;
          caddr_d   = CA_W'(col_w);
          len_d     = calc_len;
          state_d   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (b2r_ack) begin
          r2b_req_d = 1'b0;
          start_d   = 1'b0;
          first_d   = 1'b0;
          rem_d     = rem_q - LW'(len_q);
          addr_d    = addr_q + AW'(len_q);
          state_d   = last_q ? ST_IDLE : ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any request in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      id_q      <= '0;
      wr_q      <= 1'b0;
      wrap_q    <= 1'b0;
      r2b_req_q <= 1'b0;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      ba_q      <= '0;
      raddr_q   <= '0;
      caddr_q   <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      id_q      <= id_d;
      wr_q      <= wr_d;
      wrap_q    <= wrap_d;
      r2b_req_q <= r2b_req_d;
      start_q   <= start_d;
      last_q    <= last_d;
      ba_q      <= ba_d;
      raddr_q   <= raddr_d;
      caddr_q   <= caddr_d;
      len_q     <= len_d;
    end
  end

  assign r2b_req    = r2b_req_q;
  assign r2b_req_id = id_q;
  assign r2b_start  = start_q;
  assign r2b_last   = last_q;
  assign r2b_wrap   = wrap_q;
  assign r2b_ba     = ba_q;
  assign r2b_raddr  = raddr_q;
  assign r2b_caddr  = caddr_q;
  assign r2b_len    = len_q;
  assign r2b_write  = wr_q;

endmodule

`default_nettype wire

// File: tb/tb_sdrc_req_split.sv
// ============================================================================
//  Module      : tb_sdrc_req_split
//  Description : Directed self-checking bench for sdrc_req_split.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdrc_req_split;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cfg_colbits;
  logic [1:0]  sdr_width;
  logic        req;
  logic [3:0]  req_id;
  logic [25:0] req_addr;
  logic [8:0]  req_len;
  logic        req_wrap;
  logic        req_wr_n;
  logic        req_ack;
  logic        r2x_idle;
  logic        r2b_req;
  logic [3:0]  r2b_req_id;
  logic        r2b_start;
  logic        r2b_last;
  logic        r2b_wrap;
  logic [1:0]  r2b_ba;
  logic [12:0] r2b_raddr;
  logic [12:0] r2b_caddr;
  logic [11:0] r2b_len;
  logic        r2b_write;
  logic        b2r_ack;
  logic        b2r_arb_ok;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sdrc_req_split dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_colbits(cfg_colbits),
    .sdr_width  (sdr_width),
    .req        (req),
    .req_id     (req_id),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wrap   (req_wrap),
    .req_wr_n   (req_wr_n),
    .req_ack    (req_ack),
    .r2x_idle   (r2x_idle),
    .r2b_req    (r2b_req),
    .r2b_req_id (r2b_req_id),
    .r2b_start  (r2b_start),
    .r2b_last   (r2b_last),
    .r2b_wrap   (r2b_wrap),
    .r2b_ba     (r2b_ba),
    .r2b_raddr  (r2b_raddr),
    .r2b_caddr  (r2b_caddr),
    .r2b_len    (r2b_len),
    .r2b_write  (r2b_write),
    .b2r_ack    (b2r_ack),
    .b2r_arb_ok (b2r_arb_ok)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected bank after the optional row hash
  function automatic logic [1:0] exp_ba(input logic [1:0] bank, input logic [12:0] row);
`ifdef SDRC_BANK_HASH_EN
    return bank ^ row[1:0];
`else
    return bank | (row[1:0] & 2'b00);
`endif
  endfunction

  // Present a request and hold it until accepted; returns one negedge after acceptance
  task automatic do_req(input logic [3:0] id, input logic [25:0] addr,
                        input logic [8:0] len, input logic wrap, input logic wr_n);
    int t;
    req_id = id; req_addr = addr; req_len = len; req_wrap = wrap; req_wr_n = wr_n;
    req = 1'b1;
    #1;
    t = 0;
    while (req_ack !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    check("req_ack", req_ack, 1);
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  // Wait for a chunk, check latency and every field, optionally stall, then ack
  task automatic expect_chunk(input string tag, input logic [3:0] id,
                              input int len, input logic [1:0] ba,
                              input int row, input int col,
                              input logic st, input logic lst,
                              input logic wrap, input logic wr, input int hold);
    int w;
    w = 0;
    while (r2b_req !== 1'b1 && w < 20) begin @(negedge clk); #1; w++; end
    check($sformatf("%s.latency", tag), 64'(w), 64'd1);
    check($sformatf("%s.req", tag),   r2b_req, 1);
    check($sformatf("%s.id", tag),    r2b_req_id, id);
    check($sformatf("%s.len", tag),   r2b_len, 64'(len));
    check($sformatf("%s.ba", tag),    r2b_ba, ba);
    check($sformatf("%s.row", tag),   r2b_raddr, 64'(row));
    check($sformatf("%s.col", tag),   r2b_caddr, 64'(col));
    check($sformatf("%s.start", tag), r2b_start, st);
    check($sformatf("%s.last", tag),  r2b_last, lst);
    check($sformatf("%s.wrap", tag),  r2b_wrap, wrap);
    check($sformatf("%s.write", tag), r2b_write, wr);
    check($sformatf("%s.idle", tag),  r2x_idle, 0);
    for (int h = 0; h < hold; h++) begin
      req = 1'b1;
      @(negedge clk); #1;
      check($sformatf("%s.hold%0d.req", tag, h),   r2b_req, 1);
      check($sformatf("%s.hold%0d.len", tag, h),   r2b_len, 64'(len));
      check($sformatf("%s.hold%0d.col", tag, h),   r2b_caddr, 64'(col));
      check($sformatf("%s.hold%0d.ba", tag, h),    r2b_ba, ba);
      check($sformatf("%s.hold%0d.start", tag, h), r2b_start, st);
      check($sformatf("%s.hold%0d.last", tag, h),  r2b_last, lst);
      check($sformatf("%s.hold%0d.ack", tag, h),   req_ack, 0);
    end
    req = 1'b0;
    b2r_ack = 1'b1;
    @(negedge clk);
    b2r_ack = 1'b0;
    #1;
  endtask

  initial begin
    int w;
    reset_n = 1'b0; req = 1'b0; req_id = '0; req_addr = '0; req_len = '0;
    req_wrap = 1'b0; req_wr_n = 1'b1; b2r_ack = 1'b0; b2r_arb_ok = 1'b0;
    cfg_colbits = 2'b00; sdr_width = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check("rst.r2b_req", r2b_req, 0);
    check("rst.len",     r2b_len, 0);
    check("rst.caddr",   r2b_caddr, 0);
    check("rst.idle",    r2x_idle, 1);
    req = 1'b1; #1;
    check("rst.idle_req", r2x_idle, 0);
    req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; b2r_arb_ok = 1'b1;
    @(negedge clk); #1;

    // Page split plus MAX_CHUNK split, stall on the middle chunk
    do_req(4'd3, 26'h0F0, 9'd64, 1'b0, 1'b0);
    expect_chunk("s1c1", 4'd3, 16, exp_ba(2'd0, 13'd0), 0, 'hF0, 1, 0, 0, 1, 0);
    expect_chunk("s1c2", 4'd3, 32, exp_ba(2'd1, 13'd0), 0, 'h00, 0, 0, 0, 1, 5);
    expect_chunk("s1c3", 4'd3, 16, exp_ba(2'd1, 13'd0), 0, 'h20, 0, 1, 0, 1, 0);
    check("s1.idle_after", r2x_idle, 1);

    // Wrap request goes out whole (read)
    do_req(4'd5, 26'h0F0, 9'd4, 1'b1, 1'b1);
    expect_chunk("s2", 4'd5, 4, exp_ba(2'd0, 13'd0), 0, 'hF0, 1, 1, 1, 0, 0);

    // 16-bit SDRAM scaling
    sdr_width = 2'b01;
    do_req(4'd6, 26'h07C, 9'd4, 1'b0, 1'b0);
    expect_chunk("s3", 4'd6, 8, exp_ba(2'd0, 13'd0), 0, 'hF8, 1, 1, 0, 1, 0);

    // 10 column bits, nonzero bank/row, bank crossing at page end
    sdr_width = 2'b00; cfg_colbits = 2'b10;
    do_req(4'd7, 26'h3BFE, 9'd8, 1'b0, 1'b0);
    expect_chunk("s4c1", 4'd7, 2, exp_ba(2'd2, 13'd3), 3, 'h3FE, 1, 0, 0, 1, 0);
    expect_chunk("s4c2", 4'd7, 6, exp_ba(2'd3, 13'd3), 3, 'h000, 0, 1, 0, 1, 0);

    // 8-bit scaling, 2048-beat page: MAX_CHUNK alone splits 100 beats
    sdr_width = 2'b10; cfg_colbits = 2'b11;
    do_req(4'd9, 26'h010, 9'd25, 1'b0, 1'b1);
    expect_chunk("s5c1", 4'd9, 32, 2'd0, 0, 'h40, 1, 0, 0, 0, 0);
    expect_chunk("s5c2", 4'd9, 32, 2'd0, 0, 'h60, 0, 0, 0, 0, 0);
    expect_chunk("s5c3", 4'd9, 32, 2'd0, 0, 'h80, 0, 0, 0, 0, 0);
    expect_chunk("s5c4", 4'd9, 4,  2'd0, 0, 'hA0, 0, 1, 0, 0, 0);

    // Arbitration blocks acceptance; zero-length request issues nothing
    sdr_width = 2'b00; cfg_colbits = 2'b00;
    b2r_arb_ok = 1'b0; req = 1'b1; req_len = 9'd0; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arb%0d.ack", i),  req_ack, 0);
      check($sformatf("arb%0d.idle", i), r2x_idle, 0);
      @(negedge clk); #1;
    end
    b2r_arb_ok = 1'b1;
    do_req(4'd2, 26'h100, 9'd0, 1'b0, 1'b0);
    check("len0.load_req", r2b_req, 0);
    @(negedge clk); #1;
    check("len0.idle", r2x_idle, 1);
    check("len0.req",  r2b_req, 0);
    @(negedge clk); #1;
    check("len0.req2", r2b_req, 0);

    // Reset while the second chunk is on offer
    do_req(4'd3, 26'h0F0, 9'd64, 1'b0, 1'b0);
    expect_chunk("s7c1", 4'd3, 16, exp_ba(2'd0, 13'd0), 0, 'hF0, 1, 0, 0, 1, 0);
    w = 0;
    while (r2b_req !== 1'b1 && w < 20) begin @(negedge clk); #1; w++; end
    check("s7c2.req", r2b_req, 1);
    reset_n = 1'b0; #1;
    check("mrst.req",   r2b_req, 0);
    check("mrst.len",   r2b_len, 0);
    check("mrst.caddr", r2b_caddr, 0);
    check("mrst.ba",    r2b_ba, 0);
    check("mrst.id",    r2b_req_id, 0);
    check("mrst.write", r2b_write, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mrst.idle", r2x_idle, 1);
    repeat (4) @(negedge clk);
    #1;
    check("mrst.no_req", r2b_req, 0);
    check("mrst.start",  r2b_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
